mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory port. It accepts one request at a time: read or write, of size word, halfword or byte.
- It serves each request from an internal word array with a configurable read latency.
- It performs read-modify-write for sub-word stores and signals completion with a one-cycle ready pulse.
- It replaces the single-cycle memory model so that the control unit can be exercised with wait states.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; legal word index is 0..DEPTH_WORDS-1.
- READ_LAT, 1, array read latency in cycles; range 1..7.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal (treated as misaligned).
- sign  in  1  for byte/half reads: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  write data; sub-word data is taken from the low bits.
- rdata  out  32  read result; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready; 1 = request rejected.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=0, err=0, rdata=0, busy=0, latency counter=0. Array contents are not cleared. Reset mid-operation abandons the request; a pending sub-word write is never committed.
- Byte order is little-endian: byte lane k = addr[1:0] occupies bits [8k+7:8k]. Halfword lane = addr[1].
- Word index = addr[31:2]. It is out of range if >= DEPTH_WORDS.
- Accept: in IDLE with req=1 on edge T, latch we, size, sign, addr, wdata. The request is then classified:
  - Misaligned or out of range -> ERR. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Read -> WAIT.
  - Word write -> WRITE.
  - Sub-word write -> WAIT.
- FSM states: IDLE, WAIT, MERGE, WRITE, RESP, ERR.
  - WAIT: counter counts READ_LAT cycles.
    - Read: goes to RESP.
    - Sub-word write: goes to MERGE.
  - MERGE: replace the addressed lane(s) of the fetched word with wdata low bits. Array written at end of cycle. Goes to RESP.
  - WRITE: array word = wdata at end of cycle. Goes to RESP.
  - RESP: ready=1, err=0 for exactly one cycle, then IDLE.
  - ERR: ready=1, err=1, rdata=0, no array write, then IDLE.
- Latency (edge T accepts; ready high in the cycle after the listed edge):
  - Error: ready after T+1.
  - Word write: ready after T+2.
  - Read: ready after T+1+READ_LAT.
  - Sub-word write: ready after T+2+READ_LAT.
- Read data is computed from the fetched word:
  - Byte: lane bits, sign- or zero-extended per sign.
  - Half: lane bits, sign- or zero-extended per sign.
  - Word: unchanged.
- rdata holds its last value while ready=0. Consumers must not use it then.
- req outside IDLE is ignored; nothing is queued.
- If req is still high in the cycle after RESP/ERR (state IDLE), a new request is accepted. The initiator must drop req in the ready cycle to avoid a repeat.
- No write ever reaches the array from ERR, or from a write whose address fails the checks.

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10);
  - FSM state encoding;
  - the READ_LAT maximum.
- One sub-module is natural: mem_lane_align.
  - It is combinational.
  - Given a word, addr[1:0], size, sign and wdata, it produces the extended read value and the merged write word.
  - It is shared by the RESP and MERGE paths.

Test Plan:
- Word round trip, READ_LAT=1: write addr=0x10, wdata=0xDEADBEEF. Expect ready after 2 edges, err=0. Then read addr=0x10; expect ready 2 cycles after accept with rdata=0xDEADBEEF.
- Byte store merge: preload word 0x11223344 at 0x20. Store byte addr=0x22, wdata=0x000000AB; ready at T+2+READ_LAT. Read word 0x20 -> 0x11AB3344.
- Sign extension: word 0x80FF7F01 at 0x30.
  - lb addr=0x31, sign=1 -> 0x0000007F.
  - lb addr=0x33, sign=1 -> 0xFFFFFF80.
  - lh addr=0x32, sign=0 -> 0x000080FF.
- Errors:
  - Word read addr=0x41 -> ready+err after 1 cycle, rdata=0.
  - Write addr=4*DEPTH_WORDS -> err=1, and word 0 is unchanged.
- Reset mid-RMW: half store in MERGE, assert reset=0 asynchronously. Expect immediate ready=0, busy=0; afterwards target word unchanged.
- Held req and ignored req: keep req=1 through the ready cycle and expect a second identical access to be accepted. Pulse req during WAIT and expect it ignored, with no extra ready pulse.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and latency limit.
package mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam int unsigned READ_LAT_MAX = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MERGE,
        ST_WRITE,
        ST_RESP,
        ST_ERR
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// Combinational lane steering: extracts/extends sub-word read data and merges
// sub-word store data into a fetched word (little-endian lanes).
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] rvalue,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_BYTE: rvalue = {{24{sign & byte_v[7]}}, byte_v};
            SZ_HALF: rvalue = {{16{sign & half_v[15]}}, half_v};
            default: rvalue = word;
        endcase

        merged = word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: one request at a time, configurable read latency,
// read-modify-write for sub-word stores, one-cycle ready pulse on completion.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);
    localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);

    state_t state, state_next;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             we_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [1:0]       lane_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      fetched;
    logic [2:0]       cnt;

    logic        accept;
    logic        bad_req;
    logic        wait_done;
    logic [31:0] align_word;
    logic [31:0] align_rvalue;
    logic [31:0] align_merged;

    assign accept    = (state == ST_IDLE) && req;
    assign bad_req   = is_misaligned(size, addr[1:0]) || (addr[31:2] >= DEPTH_L);
    assign wait_done = (state == ST_WAIT) && (cnt == LAT_LAST);

    // Array is read combinationally on the final WAIT cycle; MERGE works from the captured copy.
    assign align_word = (state == ST_MERGE) ? fetched : mem[idx_q];

    mem_lane_align u_align (
        .word   (align_word),
        .lane   (lane_q),
        .size   (size_q),
        .sign   (sign_q),
        .wdata  (wdata_q),
        .rvalue (align_rvalue),
        .merged (align_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (bad_req)            state_next = ST_ERR;
                    else if (!we)           state_next = ST_WAIT;
                    else if (size == SZ_WORD) state_next = ST_WRITE;
                    else                    state_next = ST_WAIT;
                end
            end
            ST_WAIT:  if (cnt == LAT_LAST) state_next = we_q ? ST_MERGE : ST_RESP;
            ST_MERGE: state_next = ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_RESP) || (state == ST_ERR);
        err   = (state == ST_ERR);
        busy  = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            lane_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            fetched <= '0;
            cnt     <= '0;
            rdata   <= '0;
        end else begin
            if (accept) begin
                we_q    <= we;
                size_q  <= size;
                sign_q  <= sign;
                lane_q  <= addr[1:0];
                idx_q   <= addr[IDX_W+1:2];
                wdata_q <= wdata;
                if (bad_req) rdata <= '0;
            end
            if (state == ST_WAIT) cnt <= (cnt == LAT_LAST) ? '0 : cnt + 3'd1;
            else                  cnt <= '0;
            if (wait_done) begin
                fetched <= mem[idx_q];
                if (!we_q) rdata <= align_rvalue;
            end
        end
    end

    // No reset here: contents survive reset, and an abandoned RMW never reaches MERGE.
    always_ff @(posedge clk) begin
        if ((state == ST_MERGE) || (state == ST_WRITE)) mem[idx_q] <= align_merged;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH_WORDS=256, READ_LAT=1).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    mem_responder #(.DEPTH_WORDS(256), .READ_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .size  (size),
        .sign  (sign),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, measures edges-to-ready (1 = ready right after accept edge).
    task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input int exp_lat, input logic exp_err,
                             input logic chk_rd, input logic [31:0] exp_rd);
        int lat;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (ready !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".ready"}, {31'd0, ready}, 32'd1);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        if (chk_rd) check({tag, ".rdata"}, rdata, exp_rd);
        @(posedge clk); #1;
        check({tag, ".pulse"}, {30'd0, ready, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10; sign = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.outs", {rdata[0 +: 29], ready, err, busy}, 32'd0);
        check("reset.rdata", rdata, 32'd0);
        @(negedge clk); reset = 1'b1;

        // word round trip
        do_access("wr10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 1'b0, '0);
        do_access("rd10", 1'b0, 2'b10, 1'b0, 32'h10, '0, 2, 1'b0, 1'b1, 32'hDEADBEEF);

        // byte store merge
        do_access("wr20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 2, 1'b0, 1'b0, '0);
        do_access("sb22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AB, 3, 1'b0, 1'b0, '0);
        do_access("rd20", 1'b0, 2'b10, 1'b0, 32'h20, '0, 2, 1'b0, 1'b1, 32'h11AB3344);

        // half store merge onto DEADBEEF upper lane
        do_access("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 3, 1'b0, 1'b0, '0);
        do_access("rd10b", 1'b0, 2'b10, 1'b0, 32'h10, '0, 2, 1'b0, 1'b1, 32'hBEEFBEEF);

        // sign/zero extension
        do_access("wr30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 2, 1'b0, 1'b0, '0);
        do_access("lb31s", 1'b0, 2'b00, 1'b1, 32'h31, '0, 2, 1'b0, 1'b1, 32'h0000007F);
        do_access("lb33s", 1'b0, 2'b00, 1'b1, 32'h33, '0, 2, 1'b0, 1'b1, 32'hFFFFFF80);
        do_access("lb33u", 1'b0, 2'b00, 1'b0, 32'h33, '0, 2, 1'b0, 1'b1, 32'h00000080);
        do_access("lh32u", 1'b0, 2'b01, 1'b0, 32'h32, '0, 2, 1'b0, 1'b1, 32'h000080FF);
        do_access("lh32s", 1'b0, 2'b01, 1'b1, 32'h32, '0, 2, 1'b0, 1'b1, 32'hFFFF80FF);
        do_access("lh30s", 1'b0, 2'b01, 1'b1, 32'h30, '0, 2, 1'b0, 1'b1, 32'h00007F01);

        // errors
        do_access("wr0", 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 2, 1'b0, 1'b0, '0);
        do_access("rd41", 1'b0, 2'b10, 1'b0, 32'h41, '0, 1, 1'b1, 1'b1, 32'h0);
        do_access("lh31", 1'b0, 2'b01, 1'b0, 32'h31, '0, 1, 1'b1, 1'b1, 32'h0);
        do_access("sz11", 1'b0, 2'b11, 1'b0, 32'h40, '0, 1, 1'b1, 1'b1, 32'h0);
        do_access("wroor", 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 1, 1'b1, 1'b1, 32'h0);
        do_access("sboor", 1'b1, 2'b00, 1'b0, 32'h401, 32'h000000EE, 1, 1'b1, 1'b1, 32'h0);
        do_access("rd0", 1'b0, 2'b10, 1'b0, 32'h0, '0, 2, 1'b0, 1'b1, 32'hCAFEF00D);

        // last legal word
        do_access("wr3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A5A5A5, 2, 1'b0, 1'b0, '0);
        do_access("rd3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, '0, 2, 1'b0, 1'b1, 32'hA5A5A5A5);

        // reset while the half store sits in MERGE
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b01; sign = 1'b0; addr = 32'h22; wdata = 32'h00005555;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rst.busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst.async", {30'd0, ready, busy}, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        do_access("rd20r", 1'b0, 2'b10, 1'b0, 32'h20, '0, 2, 1'b0, 1'b1, 32'h11AB3344);

        // req held through the ready cycle -> second identical access
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h10;
        @(posedge clk); #1;
        check("hold.wait", {30'd0, ready, busy}, 32'd1);
        @(posedge clk); #1;
        check("hold.resp1", {30'd0, ready, busy}, 32'd3);
        check("hold.rdata1", rdata, 32'hBEEFBEEF);
        @(posedge clk); #1;
        check("hold.idle", {30'd0, ready, busy}, 32'd0);
        @(posedge clk); #1;
        check("hold.wait2", {30'd0, ready, busy}, 32'd1);
        @(posedge clk); #1;
        check("hold.resp2", {30'd0, ready, busy}, 32'd3);
        check("hold.rdata2", rdata, 32'hBEEFBEEF);
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        check("hold.end", {30'd0, ready, busy}, 32'd0);

        // req pulsed during WAIT is ignored
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h30;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; addr = 32'h20;
        @(posedge clk); #1;
        check("ign.resp", {30'd0, ready, busy}, 32'd3);
        check("ign.rdata", rdata, 32'h80FF7F01);
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        check("ign.idle", {30'd0, ready, busy}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("ign.noextra", {30'd0, ready, busy}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
